// File: rtl/pre_data_buffer_fifo.sv
// Bundle FIFO: each entry stores data_points words of N+1 bits, written and
// read as a whole. Registered read port, one-cycle accept strobes.
module pre_data_buffer_fifo #(
  parameter int unsigned N           = 8,
  parameter int unsigned data_points = 5,
  parameter int unsigned N_specs     = 3
) (
  input  logic                            data_clk,
  input  logic                            sclr,
  input  logic [data_points-1:0][N:0]     data_in,
  input  logic                            wready,
  input  logic                            rready,
  output logic [data_points-1:0][N:0]     data_out,
  output logic                            empty,
  output logic                            full,
  output logic                            wvalid,
  output logic                            rvalid,
  output logic [N_specs:0]                fill_count
);

  localparam int unsigned Depth = 2 ** N_specs;
  localparam logic [N_specs:0] DepthCnt = (N_specs + 1)'(Depth);
  localparam logic [N_specs:0] CntOne   = (N_specs + 1)'(1);
  localparam logic [N_specs-1:0] PtrOne = N_specs'(1);

  typedef logic [data_points-1:0][N:0] bundle_t;

  bundle_t            mem_q [Depth];
  logic [N_specs-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_specs-1:0] rd_ptr_q, rd_ptr_d;
  logic [N_specs:0]   count_q, count_d;
  bundle_t            data_out_q, data_out_d;
  logic               wvalid_q, wvalid_d;
  logic               rvalid_q, rvalid_d;
  logic               wr_en, rd_en;

  // Flags come from the registered count, so accepts never see same-cycle effects.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DepthCnt);
    wr_en = wready && !full;
    rd_en = rready && !empty;
  end

  // Next-state for pointers, count, read register and strobes.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    wvalid_d   = wr_en;
    rvalid_d   = rd_en;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = mem_q[rd_ptr_q];
    end
    if (wr_en && !rd_en) count_d = count_q + CntOne;
    else if (rd_en && !wr_en) count_d = count_q - CntOne;
  end

  // Control state with synchronous reset.
  always_ff @(posedge data_clk) begin
    if (sclr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      wvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      wvalid_q   <= wvalid_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Storage array; contents survive reset since pointers make them unreachable.
  always_ff @(posedge data_clk) begin
    if (!sclr && wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out   = data_out_q;
  assign wvalid     = wvalid_q;
  assign rvalid     = rvalid_q;
  assign fill_count = count_q;

endmodule

// File: tb/tb_pre_data_buffer_fifo.sv
// Bench for pre_data_buffer_fifo: directed vector table, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_pre_data_buffer_fifo;

  localparam int unsigned N = 8;
  localparam int unsigned Dp = 5;
  localparam int unsigned Ns = 3;
  localparam int unsigned Depth = 8;

  typedef logic [Dp-1:0][N:0] bundle_t;

  logic          clk = 1'b0;
  logic          sclr = 1'b1;
  bundle_t       data_in = '0;
  logic          wready = 1'b0;
  logic          rready = 1'b0;
  bundle_t       data_out;
  logic          empty, full, wvalid, rvalid;
  logic [Ns:0]   fill_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model state.
  bundle_t q[$];
  bundle_t m_dout = '0;
  logic    m_wv = 1'b0;
  logic    m_rv = 1'b0;

  always #5 clk = ~clk;

  pre_data_buffer_fifo #(.N(N), .data_points(Dp), .N_specs(Ns)) dut (
    .data_clk  (clk),
    .sclr      (sclr),
    .data_in   (data_in),
    .wready    (wready),
    .rready    (rready),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .wvalid    (wvalid),
    .rvalid    (rvalid),
    .fill_count(fill_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input int w0, input int w1, input int w2, input int w3,
                                 input int w4);
    bundle_t b;
    b[0] = 9'(w0); b[1] = 9'(w1); b[2] = 9'(w2); b[3] = 9'(w3); b[4] = 9'(w4);
    return b;
  endfunction

  function automatic bundle_t fillb(input int k);
    return mk(k, k, k, k, k);
  endfunction

  // One clock: drive, advance the model across the edge, compare 1ns after it.
  task automatic step(input logic s, input logic w, input logic r, input bundle_t d);
    bit wacc, racc;
    sclr = s; wready = w; rready = r; data_in = d;
    @(posedge clk);
    if (s) begin
      q.delete(); m_dout = '0; m_wv = 1'b0; m_rv = 1'b0;
    end else begin
      wacc = w && (q.size() < Depth);
      racc = r && (q.size() > 0);
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      m_wv = wacc; m_rv = racc;
    end
    #1;
    chk("fill_count", 64'(fill_count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == Depth));
    chk("wvalid", 64'(wvalid), 64'(m_wv));
    chk("rvalid", 64'(rvalid), 64'(m_rv));
    chk("data_out", 64'(data_out), 64'(m_dout));
  endtask

  typedef struct {
    logic    s, w, r;
    bundle_t d;
    int      e_fill;
    logic    e_empty, e_full, e_wv, e_rv;
    bundle_t e_dout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bundle_t b0;
    b0 = mk('h0c0, 'h0ff, 'h0ee, 'h00f, 'h0f0);
    //          s     w     r     d    fill emp   full  wv    rv    dout
    vecs[0] = '{1'b1, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, '0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, '0, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 1'b0, 1'b1, b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0, 1'b0, 1'b0, b0};

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].d);
      chk("vec_fill", 64'(fill_count), 64'(vecs[i].e_fill));
      chk("vec_empty", 64'(empty), 64'(vecs[i].e_empty));
      chk("vec_full", 64'(full), 64'(vecs[i].e_full));
      chk("vec_wvalid", 64'(wvalid), 64'(vecs[i].e_wv));
      chk("vec_rvalid", 64'(rvalid), 64'(vecs[i].e_rv));
      chk("vec_dout", 64'(data_out), 64'(vecs[i].e_dout));
    end

    // Fill to full; writes 8 and 9 must be dropped.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, fillb(k));
      if (k >= 8) chk("drop_wvalid", 64'(wvalid), 64'(0));
    end
    chk("full_reached", 64'(full), 64'(1));
    chk("full_count", 64'(fill_count), 64'(8));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk("drain_order", 64'(data_out), 64'(fillb(k)));
    end
    chk("drained_empty", 64'(empty), 64'(1));

    // Simultaneous read/write at fill_count = 3.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, fillb(20 + k));
    step(1'b0, 1'b1, 1'b1, fillb(30));
    chk("simul_fill", 64'(fill_count), 64'(3));
    chk("simul_dout", 64'(data_out), 64'(fillb(20)));
    chk("simul_strobes", 64'({wvalid, rvalid}), 64'(2'b11));

    // Simultaneous at full: only the read goes through.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, fillb(40 + k));
    step(1'b0, 1'b1, 1'b1, fillb(50));
    chk("full_simul_wv", 64'(wvalid), 64'(0));
    chk("full_simul_fill", 64'(fill_count), 64'(7));
    while (q.size() > 0) step(1'b0, 1'b0, 1'b1, '0);

    // Simultaneous at empty: write only, no fall-through.
    step(1'b0, 1'b1, 1'b1, fillb(60));
    chk("empty_simul_rv", 64'(rvalid), 64'(0));
    step(1'b0, 1'b0, 1'b1, '0);
    chk("no_fallthru", 64'(data_out), 64'(fillb(60)));

    // Interleaved traffic across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), fillb(100 + i));
    while (q.size() > 0) step(1'b0, 1'b0, 1'b1, '0);

    // Mid-stream reset with 4 stored.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, fillb(200 + k));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_fill", 64'(fill_count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    step(1'b0, 1'b0, 1'b1, '0);
    chk("rst_no_rvalid", 64'(rvalid), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bundle_t d;
      for (int j = 0; j < Dp; j++) d[j] = 9'($urandom);
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) != 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
